// File: rtl/ir_pkg.sv
// Shared types and constants for the Samsung IR receiver and the command logic it feeds.
// All windows are in timing ticks and inclusive.
package ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StDone,
    StErr,
    StWaitIdle
  } ir_state_e;

  localparam logic [9:0] LEAD_MIN   = 10'd360;
  localparam logic [9:0] LEAD_MAX   = 10'd540;
  localparam logic [9:0] MARK_MIN   = 10'd30;
  localparam logic [9:0] MARK_MAX   = 10'd90;
  localparam logic [9:0] ZERO_MIN   = 10'd30;
  localparam logic [9:0] ZERO_MAX   = 10'd90;
  localparam logic [9:0] ONE_MIN    = 10'd130;
  localparam logic [9:0] ONE_MAX    = 10'd220;
  localparam logic [9:0] DUR_SAT    = 10'd1023;
  localparam logic [9:0] IDLE_TICKS = 10'd100;

  // Command words as delivered: customer in [15:0], data in [23:16], inverted data in [31:24].
  localparam logic [31:0] IR_POWER = 32'hFD020707;
  localparam logic [31:0] IR_UP    = 32'h9F600707;
  localparam logic [31:0] IR_DOWN  = 32'h9E610707;
  localparam logic [31:0] IR_LEFT  = 32'h9A650707;
  localparam logic [31:0] IR_RIGHT = 32'h9D620707;
  localparam logic [31:0] IR_ENTER = 32'h97680707;

  function automatic logic in_win(input logic [9:0] d, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Synchronizes the raw IR line and only accepts a new level once it has been stable for
// GLITCH_CLKS consecutive samples; fell/rose pulse on each accepted change.
module ir_input_filter #(
  parameter int unsigned GLITCH_CLKS = 16
) (
  input  logic clk25,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fell,
  output logic rose
);

  localparam int unsigned CW = $clog2(GLITCH_CLKS) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fell  <= 1'b0;
      rose  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fell  <= 1'b0;
      rose  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(GLITCH_CLKS - 1)) begin
        cnt   <= '0;
        level <= sync2;
        fell  <= ~sync2;
        rose  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/samsung_ir_rx.sv
// Samsung IR frame receiver: measures filtered mark/space durations in ticks, assembles
// 32-bit words LSB first and hands validated words to the command logic via ready/ack.
module samsung_ir_rx
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned TICK_US     = 10,
  parameter int unsigned GLITCH_CLKS = 16,
  parameter int unsigned CHECK_DATA  = 1
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        enable,
  input  logic        ir_input,
  input  logic        ack,
  output logic        ready,
  output logic [31:0] command,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned PRE_TOP = CLK_HZ / 1000000 * TICK_US - 1;
  localparam int unsigned PRE_W   = (PRE_TOP > 0) ? $clog2(PRE_TOP + 1) : 1;

  logic level;
  logic fell;
  logic rose;

  ir_input_filter #(
    .GLITCH_CLKS(GLITCH_CLKS)
  ) u_filter (
    .clk25(clk25),
    .rst  (rst),
    .raw  (ir_input),
    .level(level),
    .fell (fell),
    .rose (rose)
  );

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (pre == PRE_W'(PRE_TOP));

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // dur_now includes a tick landing on the edge cycle, so a segment of N tick periods
  // measures exactly N regardless of the prescaler phase.
  logic [9:0] dur;
  logic [9:0] dur_now;

  assign dur_now = (tick && (dur != DUR_SAT)) ? dur + 10'd1 : dur;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      dur <= '0;
    end else if (fell || rose) begin
      dur <= '0;
    end else begin
      dur <= dur_now;
    end
  end

  ir_state_e   state;
  logic [31:0] shift;
  logic [4:0]  bit_cnt;
  logic        timeout;
  logic        lead_ok;
  logic        mark_ok;
  logic        space_zero;
  logic        space_one;
  logic        chk_ok;

  assign timeout    = (dur_now == DUR_SAT);
  assign lead_ok    = in_win(dur_now, LEAD_MIN, LEAD_MAX);
  assign mark_ok    = in_win(dur_now, MARK_MIN, MARK_MAX);
  assign space_zero = in_win(dur_now, ZERO_MIN, ZERO_MAX);
  assign space_one  = in_win(dur_now, ONE_MIN, ONE_MAX);
  assign chk_ok     = (CHECK_DATA == 0) || (shift[31:24] == ~shift[23:16]);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      shift     <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b0;
      command   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (ready && ack) begin
        ready <= 1'b0;
      end
      if (!enable) begin
        state   <= StIdle;
        shift   <= '0;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (fell) state <= StLeadMark;
          end
          StLeadMark: begin
            if (rose) state <= lead_ok ? StLeadSpace : StErr;
            else if (fell || timeout) state <= StErr;
          end
          StLeadSpace: begin
            if (fell) begin
              state   <= lead_ok ? StBitMark : StErr;
              bit_cnt <= '0;
            end else if (rose || timeout) begin
              state <= StErr;
            end
          end
          StBitMark: begin
            if (rose) state <= mark_ok ? StBitSpace : StErr;
            else if (fell || timeout) state <= StErr;
          end
          StBitSpace: begin
            if (fell) begin
              if (space_zero || space_one) begin
                shift   <= {space_one, shift[31:1]};
                bit_cnt <= bit_cnt + 5'd1;
                state   <= (bit_cnt == 5'd31) ? StDone : StBitMark;
              end else begin
                state <= StErr;
              end
            end else if (rose || timeout) begin
              state <= StErr;
            end
          end
          StDone: begin
            // Overrun decision uses ready before any same-cycle ack takes effect.
            if (!chk_ok) begin
              frame_err <= 1'b1;
            end else if (ready) begin
              overrun <= 1'b1;
            end else begin
              command <= shift;
              ready   <= 1'b1;
            end
            state <= StWaitIdle;
          end
          StErr: begin
            frame_err <= 1'b1;
            state     <= StWaitIdle;
          end
          StWaitIdle: begin
            if (level && (dur_now >= IDLE_TICKS)) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_samsung_ir_rx.sv
// Self-checking bench for samsung_ir_rx. The DUT runs with one tick per clock so that
// protocol durations (1 tick = 10 us on the real board) map directly to clock counts.
`timescale 1ns/1ps
module tb_samsung_ir_rx;
  import ir_pkg::*;

  localparam int GLITCH = 16;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ir_input = 1'b1;
  logic        ack = 1'b0;
  logic        ready;
  logic [31:0] command;
  logic        frame_err;
  logic        overrun;

  samsung_ir_rx #(
    .CLK_HZ     (1000000),
    .TICK_US    (1),
    .GLITCH_CLKS(GLITCH),
    .CHECK_DATA (1)
  ) dut (
    .clk25    (clk25),
    .rst      (rst),
    .enable   (enable),
    .ir_input (ir_input),
    .ack      (ack),
    .ready    (ready),
    .command  (command),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk25 = ~clk25;

  int          errors = 0;
  int          checks = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  logic        ready_d = 1'b0;
  logic        ready_exp = 1'b0;
  logic [31:0] cmd_exp = '0;
  int          segq[$];

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    ready_d <= ready;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (ready && !ready_d) rise_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Segment list: [0] leader mark, [1] leader space, then mark/space per bit, [66] stop mark.
  task automatic build(input logic [31:0] w, input bit jitter);
    segq.delete();
    segq.push_back(jitter ? int'($urandom_range(370, 530)) : 450);
    segq.push_back(jitter ? int'($urandom_range(370, 530)) : 450);
    for (int i = 0; i < 32; i++) begin
      segq.push_back(jitter ? int'($urandom_range(35, 85)) : 56);
      if (w[i]) segq.push_back(jitter ? int'($urandom_range(135, 215)) : 169);
      else      segq.push_back(jitter ? int'($urandom_range(35, 85)) : 56);
    end
    segq.push_back(56);
  endtask

  // Reference decode: index of the first out-of-window segment (-1 if none) and the word.
  function automatic int first_bad(output logic [31:0] w);
    int d;
    w = '0;
    for (int i = 0; i < 66; i++) begin
      d = segq[i];
      if (i < 2) begin
        if (d < 360 || d > 540) return i;
      end else if (i % 2 == 0) begin
        if (d < 30 || d > 90) return i;
      end else if (d >= 130 && d <= 220) begin
        w[(i - 3) / 2] = 1'b1;
      end else if (d < 30 || d > 90) begin
        return i;
      end
    end
    return -1;
  endfunction

  task automatic drive(input logic lvl, input int n, input bit glitch);
    ir_input = lvl;
    if (glitch) begin
      repeat (n / 2) @(negedge clk25);
      ir_input = ~lvl;
      repeat (5) @(negedge clk25);
      ir_input = lvl;
      repeat (n - n / 2 - 5) @(negedge clk25);
    end else begin
      repeat (n) @(negedge clk25);
    end
  endtask

  task automatic send(input int last, input bit glitch);
    for (int i = 0; i <= last; i++) begin
      if (i == 66) fall_cyc = cyc;
      drive((i % 2 == 0) ? 1'b0 : 1'b1, segq[i], glitch);
    end
    if (last % 2 == 1) drive(1'b0, 56, 1'b0);
    ir_input = 1'b1;
    repeat (200) @(negedge clk25);
  endtask

  task automatic play(input string tag, input bit glitch);
    logic [31:0] w;
    int          bad;
    int          f0;
    int          o0;
    bit          ferr_exp;
    bit          ovr_exp;
    bad = first_bad(w);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send((bad < 0) ? 66 : bad, glitch);
    ferr_exp = 1'b0;
    ovr_exp  = 1'b0;
    if (bad >= 0 || w[31:24] != ~w[23:16]) begin
      ferr_exp = 1'b1;
    end else if (ready_exp) begin
      ovr_exp = 1'b1;
    end else begin
      ready_exp = 1'b1;
      cmd_exp   = w;
    end
    chk({tag, ".frame_err"}, ferr_cnt - f0, 32'(ferr_exp));
    chk({tag, ".overrun"}, ovr_cnt - o0, 32'(ovr_exp));
    chk({tag, ".ready"}, 32'(ready), 32'(ready_exp));
    chk({tag, ".command"}, command, cmd_exp);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk25);
    ack = 1'b0;
    ready_exp = 1'b0;
    chk({tag, ".ack_clears"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int          f0;
    int          o0;
    logic [31:0] w;

    repeat (4) @(negedge clk25);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk25);
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.command", command, 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    repeat (50) @(negedge clk25);

    build(IR_UP, 1'b0);
    play("up", 1'b0);
    chk("up.latency_ok", 32'((rise_cyc - fall_cyc) <= GLITCH + 4), 32'd1);
    do_ack("up");

    build(32'h9E600707, 1'b0);
    play("bad_checksum", 1'b0);

    build(IR_UP, 1'b0);
    segq[0] = 359;
    play("lead_3590us", 1'b0);

    build(IR_UP, 1'b0);
    segq[3 + 2 * 5] = 221;
    play("space_2210us", 1'b0);

    build(IR_UP, 1'b0);
    for (int i = 0; i < 32; i++) segq[3 + 2 * i] = IR_UP[i] ? 130 : 90;
    play("space_1300_900", 1'b0);

    // Left un-acked so the next valid frame is dropped.
    build(IR_POWER, 1'b0);
    play("power_overrun", 1'b0);
    do_ack("power_overrun");

    f0 = ferr_cnt;
    drive(1'b0, 1200, 1'b0);
    ir_input = 1'b1;
    repeat (200) @(negedge clk25);
    chk("stuck_low.frame_err", ferr_cnt - f0, 32'd1);

    build(IR_POWER, 1'b0);
    play("glitchy_recovery", 1'b1);

    build(IR_UP, 1'b0);
    for (int i = 0; i <= 36; i++) drive((i % 2 == 0) ? 1'b0 : 1'b1, segq[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid.ready", 32'(ready), 32'd0);
    chk("rst_mid.command", command, 32'd0);
    chk("rst_mid.frame_err", 32'(frame_err), 32'd0);
    chk("rst_mid.overrun", 32'(overrun), 32'd0);
    ready_exp = 1'b0;
    cmd_exp   = '0;
    @(negedge clk25);
    ir_input = 1'b1;
    repeat (3) @(negedge clk25);
    rst = 1'b0;
    repeat (200) @(negedge clk25);

    build(IR_UP, 1'b0);
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    for (int i = 0; i <= 66; i++) begin
      if (i == 23) enable = 1'b0;
      drive((i % 2 == 0) ? 1'b0 : 1'b1, segq[i], 1'b0);
    end
    ir_input = 1'b1;
    repeat (200) @(negedge clk25);
    chk("enable_drop.frame_err", ferr_cnt - f0, 32'd0);
    chk("enable_drop.overrun", ovr_cnt - o0, 32'd0);
    chk("enable_drop.ready", 32'(ready), 32'd0);
    enable = 1'b1;
    repeat (5) @(negedge clk25);

    build(IR_DOWN, 1'b0);
    play("after_abort", 1'b0);
    do_ack("after_abort");

    for (int n = 0; n < 2; n++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[31:24] = ~w[23:16];
      build(w, 1'b1);
      if ($urandom_range(0, 3) == 0) segq[$urandom_range(0, 65)] = $urandom_range(25, 300);
      play($sformatf("random%0d", n), 1'b0);
      if (ready_exp) do_ack($sformatf("random%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
